// File: rtl/uart_frame_bit_counter.sv
// UART frame bit counter: counts bit-time strobes through one frame and
// flags end-of-frame using a format latched when the frame starts.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame active, bit_idx held at 0, waiting for doit
// RUN   | frame in progress, each btu advances bit_idx
// FULL  | bit_idx reached frame_len, saturated; extra btu sets ovr
module uart_frame_bit_counter #(
   parameter int CNT_W     = 4,
   parameter int DBIT_W    = 2,
   parameter int DATA_BASE = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              doit,
   input  logic              btu,
   input  logic [DBIT_W-1:0] dbits,
   input  logic              pen,
   input  logic              stop2,
   output logic [CNT_W-1:0]  bit_idx,
   output logic [CNT_W-1:0]  frame_len,
   output logic              done,
   output logic              done_d1,
   output logic              ovr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] bit_idx_q, bit_idx_n;
   logic [CNT_W-1:0] frame_len_q, frame_len_n;
   logic             ovr_q, ovr_n;
   logic             done_d1_q;
   logic [CNT_W-1:0] len_calc;
   logic [CNT_W-1:0] bit_idx_inc;

   // Frame length for the format currently presented on the inputs:
   // start + data + optional parity + one or two stop bits.
   always_comb begin
      len_calc = CNT_W'(DATA_BASE + 1)
               + CNT_W'(dbits)
               + CNT_W'(pen)
               + (stop2 ? CNT_W'(2) : CNT_W'(1));
   end

   assign bit_idx_inc = bit_idx_q + CNT_W'(1);

   // Registered state, counter, latched format and sticky overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         bit_idx_q   <= '0;
         frame_len_q <= '0;
         ovr_q       <= 1'b0;
         done_d1_q   <= 1'b0;
      end else begin
         state_q     <= state_n;
         bit_idx_q   <= bit_idx_n;
         frame_len_q <= frame_len_n;
         ovr_q       <= ovr_n;
         done_d1_q   <= (state_q == FULL);
      end
   end

   // Next-state logic; doit low always wins and returns to a clean IDLE.
   always_comb begin
      state_n     = state_q;
      bit_idx_n   = bit_idx_q;
      frame_len_n = frame_len_q;
      ovr_n       = ovr_q;
      case (state_q)
         IDLE: begin
            bit_idx_n = '0;
            ovr_n     = 1'b0;
            if (doit) begin
               state_n     = RUN;
               frame_len_n = len_calc;
            end
         end
         RUN: begin
            if (!doit) begin
               state_n   = IDLE;
               bit_idx_n = '0;
               ovr_n     = 1'b0;
            end else if (btu) begin
               bit_idx_n = bit_idx_inc;
               if (bit_idx_inc == frame_len_q) begin
                  state_n = FULL;
               end
            end
         end
         FULL: begin
            if (!doit) begin
               state_n   = IDLE;
               bit_idx_n = '0;
               ovr_n     = 1'b0;
            end else if (btu) begin
               ovr_n = 1'b1;
            end
         end
         default: begin
            state_n   = IDLE;
            bit_idx_n = '0;
            ovr_n     = 1'b0;
         end
      endcase
   end

   assign bit_idx   = bit_idx_q;
   assign frame_len = frame_len_q;
   assign done      = (state_q == FULL);
   assign done_d1   = done_d1_q;
   assign ovr       = ovr_q;

endmodule

// File: tb/tb_uart_frame_bit_counter.sv
// Directed bench for uart_frame_bit_counter with hand-computed expectations.
module tb_uart_frame_bit_counter;

   logic       clk;
   logic       reset;
   logic       doit;
   logic       btu;
   logic [1:0] dbits;
   logic       pen;
   logic       stop2;
   logic [3:0] bit_idx;
   logic [3:0] frame_len;
   logic       done;
   logic       done_d1;
   logic       ovr;

   int vectors     = 0;
   int miscompares = 0;

   uart_frame_bit_counter #(.CNT_W(4), .DBIT_W(2), .DATA_BASE(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .doit      (doit),
      .btu       (btu),
      .dbits     (dbits),
      .pen       (pen),
      .stop2     (stop2),
      .bit_idx   (bit_idx),
      .frame_len (frame_len),
      .done      (done),
      .done_d1   (done_d1),
      .ovr       (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) begin
         btu = 1'b1;
         tick();
         btu = 1'b0;
      end
   endtask

   task automatic start(input logic [1:0] d, input logic p, input logic s);
      dbits = d;
      pen   = p;
      stop2 = s;
      doit  = 1'b1;
      tick();
   endtask

   task automatic stop();
      doit = 1'b0;
      btu  = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      doit  = 1'b0;
      btu   = 1'b0;
      dbits = 2'd0;
      pen   = 1'b0;
      stop2 = 1'b0;
      #3;
      chk("rst_bit_idx", bit_idx, 0);
      chk("rst_frame_len", frame_len, 0);
      chk("rst_done", done, 0);
      chk("rst_done_d1", done_d1, 0);
      chk("rst_ovr", ovr, 0);
      #4 reset = 1'b1;
      tick();

      // 8E1 with btu present on the entry edge (must be ignored)
      btu = 1'b1;
      start(2'd3, 1'b1, 1'b0);
      btu = 1'b0;
      chk("t1_len", frame_len, 11);
      chk("t1_entry_idx", bit_idx, 0);
      pulse(10);
      chk("t1_idx10", bit_idx, 10);
      chk("t1_not_done", done, 0);
      pulse(1);
      chk("t1_idx11", bit_idx, 11);
      chk("t1_done", done, 1);
      chk("t1_d1_lag", done_d1, 0);
      tick();
      chk("t1_d1", done_d1, 1);
      chk("t1_hold", bit_idx, 11);
      doit = 1'b0;
      tick();
      chk("t1_exit_idx", bit_idx, 0);
      chk("t1_exit_done", done, 0);
      chk("t1_exit_d1", done_d1, 1);
      tick();
      chk("t1_d1_fall", done_d1, 0);

      // 8N1
      start(2'd3, 1'b0, 1'b0);
      chk("8n1_len", frame_len, 10);
      pulse(9);
      chk("8n1_not_done", done, 0);
      pulse(1);
      chk("8n1_done", done, 1);
      chk("8n1_idx", bit_idx, 10);
      stop();

      // 5N1
      start(2'd0, 1'b0, 1'b0);
      chk("5n1_len", frame_len, 7);
      pulse(6);
      chk("5n1_not_done", done, 0);
      pulse(1);
      chk("5n1_done", done, 1);
      chk("5n1_idx", bit_idx, 7);
      stop();

      // 8E2: maximum length, must saturate rather than wrap
      start(2'd3, 1'b1, 1'b1);
      chk("8e2_len", frame_len, 12);
      pulse(11);
      chk("8e2_not_done", done, 0);
      pulse(1);
      chk("8e2_done", done, 1);
      pulse(2);
      chk("8e2_nowrap", bit_idx, 12);
      chk("8e2_ovr", ovr, 1);
      stop();

      // Saturation / overrun on 8N1
      start(2'd3, 1'b0, 1'b0);
      pulse(10);
      chk("sat_done", done, 1);
      chk("sat_no_ovr", ovr, 0);
      pulse(3);
      chk("sat_idx", bit_idx, 10);
      chk("sat_ovr", ovr, 1);
      doit = 1'b0;
      tick();
      chk("sat_clr_idx", bit_idx, 0);
      chk("sat_clr_ovr", ovr, 0);
      chk("sat_clr_done", done, 0);
      tick();

      // Format change mid-frame is ignored until the next frame
      start(2'd3, 1'b0, 1'b0);
      pulse(4);
      dbits = 2'd0;
      pen   = 1'b1;
      stop2 = 1'b1;
      pulse(5);
      chk("fmt_idx9", bit_idx, 9);
      chk("fmt_not_done", done, 0);
      chk("fmt_len_kept", frame_len, 10);
      pulse(1);
      chk("fmt_done", done, 1);
      doit = 1'b0;
      tick();
      doit = 1'b1;
      tick();
      chk("fmt_relatch", frame_len, 9);
      stop();

      // doit low with btu in the same clock: doit wins
      start(2'd3, 1'b0, 1'b0);
      pulse(6);
      chk("abort_idx6", bit_idx, 6);
      doit = 1'b0;
      btu  = 1'b1;
      tick();
      btu = 1'b0;
      chk("abort_idx", bit_idx, 0);
      chk("abort_done", done, 0);
      doit = 1'b1;
      tick();
      chk("restart_idx0", bit_idx, 0);
      pulse(1);
      chk("restart_idx1", bit_idx, 1);
      stop();

      // Async reset between edges while running
      start(2'd3, 1'b0, 1'b0);
      pulse(5);
      chk("ar_idx5", bit_idx, 5);
      #3 reset = 1'b0;
      #1;
      chk("ar_idx", bit_idx, 0);
      chk("ar_len", frame_len, 0);
      chk("ar_done", done, 0);
      chk("ar_d1", done_d1, 0);
      chk("ar_ovr", ovr, 0);
      #2 reset = 1'b1;
      doit = 1'b0;
      btu  = 1'b1;
      tick();
      chk("ar_post_idx", bit_idx, 0);
      tick();
      btu = 1'b0;
      chk("ar_post_idx2", bit_idx, 0);
      chk("ar_post_done", done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
